// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the rename-aware architectural register file.
// Imported by the register file top and its read-port helper.
package reg_file_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_N     = 32;
    localparam int unsigned ROB_ID_W  = 4;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // A rename or commit only has an architectural effect when it targets a real register.
    function automatic logic writes_reg(input logic valid, input logic [REG_IDX_W-1:0] rd);
        return valid && (rd != '0);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational source-operand read port: x0 gating plus same-cycle commit forwarding.
// The caller supplies the already-selected register entry.
module rf_read_port #(
    parameter int unsigned DATA_W   = reg_file_pkg::DATA_W,
    parameter int unsigned ROB_ID_W = reg_file_pkg::ROB_ID_W
) (
    input  logic [reg_file_pkg::REG_IDX_W-1:0] rs,
    input  logic [DATA_W-1:0]                  reg_value,
    input  logic                               reg_busy,
    input  logic [ROB_ID_W-1:0]                reg_tag,
    input  logic                               commit_fire,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_ID_W-1:0]                commit_rob_id,
    input  logic [DATA_W-1:0]                  commit_value,
    output logic [DATA_W-1:0]                  value,
    output logic                               busy,
    output logic [ROB_ID_W-1:0]                rob_id
);
    import reg_file_pkg::*;

    always_comb begin
        value  = reg_value;
        busy   = reg_busy;
        rob_id = reg_tag;
        if (rs == '0) begin
            value  = '0;
            busy   = FALSE;
            rob_id = '0;
        end else if (commit_fire && (commit_rd == rs) && (reg_tag == commit_rob_id)) begin
            // The retiring producer is the one this register waits on: hand its value over now.
            value  = commit_value;
            busy   = FALSE;
            rob_id = commit_rob_id;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags, commit forwarding and rollback.
// Two combinational read ports; all state updates on the rising edge, gated by rdy.
module reg_file #(
    parameter int unsigned DATA_W   = reg_file_pkg::DATA_W,
    parameter int unsigned REG_N    = reg_file_pkg::REG_N,
    parameter int unsigned ROB_ID_W = reg_file_pkg::ROB_ID_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rdy,
    input  logic                               ID_rename_valid,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] ID_rename_rd,
    input  logic [ROB_ID_W-1:0]                ID_rename_ROB_id,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] ID_rs1,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] ID_rs2,
    output logic [DATA_W-1:0]                  RS_rs1_value,
    output logic [DATA_W-1:0]                  RS_rs2_value,
    output logic                               RS_rs1_busy,
    output logic                               RS_rs2_busy,
    output logic [ROB_ID_W-1:0]                RS_rs1_ROB_id,
    output logic [ROB_ID_W-1:0]                RS_rs2_ROB_id,
    input  logic                               ROB_commit_valid,
    input  logic [reg_file_pkg::REG_IDX_W-1:0] ROB_commit_rd,
    input  logic [ROB_ID_W-1:0]                ROB_commit_ROB_id,
    input  logic [DATA_W-1:0]                  ROB_commit_value,
    input  logic                               ROB_roll_back_flag
);
    import reg_file_pkg::*;

    logic [DATA_W-1:0]   value_q [REG_N];
    logic [DATA_W-1:0]   value_d [REG_N];
    logic [ROB_ID_W-1:0] tag_q   [REG_N];
    logic [ROB_ID_W-1:0] tag_d   [REG_N];
    logic [REG_N-1:0]    busy_q;
    logic [REG_N-1:0]    busy_d;

    logic commit_fire;
    logic rename_fire;

    // A frozen pipeline must not forward a commit that will not actually retire.
    assign commit_fire = rdy && writes_reg(ROB_commit_valid, ROB_commit_rd);
    assign rename_fire = writes_reg(ID_rename_valid, ID_rename_rd);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rdy) begin
            for (int unsigned i = 1; i < REG_N; i++) begin
                if (commit_fire && (ROB_commit_rd == REG_IDX_W'(i))) begin
                    value_d[i] = ROB_commit_value;
                    // A younger rename keeps the register busy under its own tag.
                    if (tag_q[i] == ROB_commit_ROB_id) begin
                        busy_d[i] = FALSE;
                    end
                end
                if (ROB_roll_back_flag) begin
                    busy_d[i] = FALSE;
                end else if (rename_fire && (ID_rename_rd == REG_IDX_W'(i))) begin
                    busy_d[i] = TRUE;
                    tag_d[i]  = ID_rename_ROB_id;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
            busy_q  <= busy_d;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W)
    ) u_rd_port1 (
        .rs            (ID_rs1),
        .reg_value     (value_q[ID_rs1]),
        .reg_busy      (busy_q[ID_rs1]),
        .reg_tag       (tag_q[ID_rs1]),
        .commit_fire   (commit_fire),
        .commit_rd     (ROB_commit_rd),
        .commit_rob_id (ROB_commit_ROB_id),
        .commit_value  (ROB_commit_value),
        .value         (RS_rs1_value),
        .busy          (RS_rs1_busy),
        .rob_id        (RS_rs1_ROB_id)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ROB_ID_W (ROB_ID_W)
    ) u_rd_port2 (
        .rs            (ID_rs2),
        .reg_value     (value_q[ID_rs2]),
        .reg_busy      (busy_q[ID_rs2]),
        .reg_tag       (tag_q[ID_rs2]),
        .commit_fire   (commit_fire),
        .commit_rd     (ROB_commit_rd),
        .commit_rob_id (ROB_commit_ROB_id),
        .commit_value  (ROB_commit_value),
        .value         (RS_rs2_value),
        .busy          (RS_rs2_busy),
        .rob_id        (RS_rs2_ROB_id)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus a model-driven random phase,
// expectations queued when stimulus is driven and compared against the read ports.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ID_rename_valid;
    logic [4:0]  ID_rename_rd;
    logic [3:0]  ID_rename_ROB_id;
    logic [4:0]  ID_rs1;
    logic [4:0]  ID_rs2;
    logic [31:0] RS_rs1_value;
    logic [31:0] RS_rs2_value;
    logic        RS_rs1_busy;
    logic        RS_rs2_busy;
    logic [3:0]  RS_rs1_ROB_id;
    logic [3:0]  RS_rs2_ROB_id;
    logic        ROB_commit_valid;
    logic [4:0]  ROB_commit_rd;
    logic [3:0]  ROB_commit_ROB_id;
    logic [31:0] ROB_commit_value;
    logic        ROB_roll_back_flag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          port;
        logic [31:0] val;
        logic        busy;
        logic [3:0]  tag;
    } exp_t;

    exp_t sbq[$];

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    always #5 clk = ~clk;

    reg_file dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .ID_rename_valid    (ID_rename_valid),
        .ID_rename_rd       (ID_rename_rd),
        .ID_rename_ROB_id   (ID_rename_ROB_id),
        .ID_rs1             (ID_rs1),
        .ID_rs2             (ID_rs2),
        .RS_rs1_value       (RS_rs1_value),
        .RS_rs2_value       (RS_rs2_value),
        .RS_rs1_busy        (RS_rs1_busy),
        .RS_rs2_busy        (RS_rs2_busy),
        .RS_rs1_ROB_id      (RS_rs1_ROB_id),
        .RS_rs2_ROB_id      (RS_rs2_ROB_id),
        .ROB_commit_valid   (ROB_commit_valid),
        .ROB_commit_rd      (ROB_commit_rd),
        .ROB_commit_ROB_id  (ROB_commit_ROB_id),
        .ROB_commit_value   (ROB_commit_value),
        .ROB_roll_back_flag (ROB_roll_back_flag)
    );

    function automatic void push_exp(input string n, input bit p, input logic [31:0] v,
                                     input logic b, input logic [3:0] t);
        exp_t e;
        e.name = n;
        e.port = p;
        e.val  = v;
        e.busy = b;
        e.tag  = t;
        sbq.push_back(e);
    endfunction

    task automatic clear_inputs();
        ID_rename_valid    = 1'b0;
        ID_rename_rd       = '0;
        ID_rename_ROB_id   = '0;
        ROB_commit_valid   = 1'b0;
        ROB_commit_rd      = '0;
        ROB_commit_ROB_id  = '0;
        ROB_commit_value   = '0;
        ROB_roll_back_flag = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] tag);
        ID_rename_valid  = 1'b1;
        ID_rename_rd     = rd;
        ID_rename_ROB_id = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] v);
        ROB_commit_valid  = 1'b1;
        ROB_commit_rd     = rd;
        ROB_commit_ROB_id = tag;
        ROB_commit_value  = v;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [36:0] got;
        clear_inputs();
        rdy = 1'b1;
        ID_rs1 = 5'd5;
        ID_rs2 = 5'd31;
        push_exp("reset_rs1", 0, 32'h0, 1'b0, 4'd0);
        push_exp("reset_rs2", 1, 32'h0, 1'b0, 4'd0);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front(); total++;
            got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                         : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
            if (got !== {e.val, e.busy, e.tag}) begin
                bad++;
                $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                         e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_rename_read();
        exp_t e;
        logic [36:0] got;
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            clear_inputs();
            ID_rs1 = 5'd5;
            if (step == 0) begin
                rename(5'd5, 4'd3);
                push_exp("rename_not_seen_same_cycle", 0, 32'h0, 1'b0, 4'd0);
            end else begin
                push_exp("rename_busy_tag", 0, 32'h0, 1'b1, 4'd3);
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_commit_forward();
        exp_t e;
        logic [36:0] got;
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            clear_inputs();
            ID_rs1 = 5'd5;
            ID_rs2 = 5'd5;
            if (step == 0) begin
                commit(5'd5, 4'd3, 32'hDEADBEEF);
                push_exp("commit_fwd_rs1", 0, 32'hDEADBEEF, 1'b0, 4'd3);
                push_exp("commit_fwd_rs2", 1, 32'hDEADBEEF, 1'b0, 4'd3);
            end else begin
                push_exp("commit_written", 0, 32'hDEADBEEF, 1'b0, 4'd3);
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_younger_rename();
        exp_t e;
        logic [36:0] got;
        @(negedge clk); clear_inputs(); rename(5'd7, 4'd2);
        @(negedge clk); clear_inputs(); rename(5'd7, 4'd9);
        for (int step = 0; step < 4; step++) begin
            @(negedge clk);
            clear_inputs();
            ID_rs1 = 5'd7;
            ID_rs2 = 5'd7;
            case (step)
                0: begin
                    commit(5'd7, 4'd2, 32'h11);
                    push_exp("stale_commit_no_fwd", 0, 32'h0, 1'b1, 4'd9);
                end
                1: push_exp("stale_commit_keeps_busy", 0, 32'h11, 1'b1, 4'd9);
                2: begin
                    commit(5'd7, 4'd9, 32'h22);
                    push_exp("young_commit_fwd", 1, 32'h22, 1'b0, 4'd9);
                end
                default: push_exp("young_commit_clears", 1, 32'h22, 1'b0, 4'd9);
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        logic [36:0] got;
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            clear_inputs();
            ID_rs1 = 5'd0;
            ID_rs2 = 5'd0;
            if (step == 0) begin
                rename(5'd0, 4'd4);
                commit(5'd0, 4'd0, 32'h55);
            end
            push_exp("x0_rs1", 0, 32'h0, 1'b0, 4'd0);
            push_exp("x0_rs2", 1, 32'h0, 1'b0, 4'd0);
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_rename_commit_same();
        exp_t e;
        logic [36:0] got;
        @(negedge clk); clear_inputs(); rename(5'd9, 4'd5);
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            clear_inputs();
            ID_rs1 = 5'd9;
            if (step == 0) begin
                rename(5'd9, 4'd6);
                commit(5'd9, 4'd5, 32'h99);
                push_exp("same_rd_fwd", 0, 32'h99, 1'b0, 4'd5);
            end else begin
                push_exp("same_rd_rename_wins", 0, 32'h99, 1'b1, 4'd6);
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_roll_back();
        exp_t e;
        logic [36:0] got;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            clear_inputs();
            rename(5'(r), 4'(r));
        end
        for (int step = 0; step < 4; step++) begin
            @(negedge clk);
            clear_inputs();
            case (step)
                0: begin
                    rename(5'd6, 4'd7);
                    commit(5'd2, 4'd2, 32'h2222);
                    ROB_roll_back_flag = 1'b1;
                    ID_rs1 = 5'd4; ID_rs2 = 5'd2;
                    push_exp("rb_pre_x4", 0, 32'h0, 1'b1, 4'd4);
                    push_exp("rb_pre_x2_fwd", 1, 32'h2222, 1'b0, 4'd2);
                end
                1: begin
                    ID_rs1 = 5'd1; ID_rs2 = 5'd3;
                    push_exp("rb_x1", 0, 32'h0, 1'b0, 4'd1);
                    push_exp("rb_x3", 1, 32'h0, 1'b0, 4'd3);
                end
                2: begin
                    ID_rs1 = 5'd4; ID_rs2 = 5'd6;
                    push_exp("rb_x4", 0, 32'h0, 1'b0, 4'd4);
                    push_exp("rb_x6_rename_dropped", 1, 32'h0, 1'b0, 4'd0);
                end
                default: begin
                    ID_rs1 = 5'd2; ID_rs2 = 5'd9;
                    push_exp("rb_x2_commit_written", 0, 32'h2222, 1'b0, 4'd2);
                    push_exp("rb_x9", 1, 32'h99, 1'b0, 4'd6);
                end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_rdy_hold();
        exp_t e;
        logic [36:0] got;
        @(negedge clk); clear_inputs(); rename(5'd12, 4'd10);
        @(negedge clk);
        clear_inputs();
        rdy = 1'b0;
        rename(5'd10, 4'd8);
        commit(5'd11, 4'd0, 32'h77);
        ROB_roll_back_flag = 1'b1;
        for (int step = 0; step < 2; step++) begin
            @(negedge clk);
            clear_inputs();
            rdy = 1'b1;
            if (step == 0) begin
                ID_rs1 = 5'd10; ID_rs2 = 5'd11;
                push_exp("hold_no_rename", 0, 32'h0, 1'b0, 4'd0);
                push_exp("hold_no_commit", 1, 32'h0, 1'b0, 4'd0);
            end else begin
                ID_rs1 = 5'd12;
                push_exp("hold_no_roll_back", 0, 32'h0, 1'b1, 4'd10);
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [36:0] got;
        @(negedge clk); clear_inputs(); rename(5'd8, 4'd1);
        for (int step = 0; step < 4; step++) begin
            if (step != 1) @(negedge clk);
            case (step)
                0: begin
                    clear_inputs();
                    ID_rs1 = 5'd8; ID_rs2 = 5'd5;
                    push_exp("pre_reset_x8", 0, 32'h0, 1'b1, 4'd1);
                    push_exp("pre_reset_x5", 1, 32'hDEADBEEF, 1'b0, 4'd3);
                end
                1: begin
                    // Reset lands between edges with a rename pending.
                    #2;
                    rename(5'd8, 4'd1);
                    rst = 1'b0;
                    push_exp("async_reset_x8", 0, 32'h0, 1'b0, 4'd0);
                    push_exp("async_reset_x5", 1, 32'h0, 1'b0, 4'd0);
                end
                2: begin
                    push_exp("reset_held_rename_dropped", 0, 32'h0, 1'b0, 4'd0);
                end
                default: begin
                    push_exp("post_release_idle", 0, 32'h0, 1'b0, 4'd0);
                end
            endcase
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
            if (step == 2) begin
                clear_inputs();
                rst = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [36:0] got;
        logic [4:0]  rs;
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            clear_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 1) == 1)
                rename(5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            if (rdy && $urandom_range(0, 1) == 1) begin
                ROB_commit_rd = 5'($urandom_range(0, 7));
                commit(ROB_commit_rd,
                       ($urandom_range(0, 9) < 7) ? m_tag[ROB_commit_rd] : 4'($urandom_range(0, 15)),
                       $urandom);
            end
            ROB_roll_back_flag = ($urandom_range(0, 19) == 0);
            ID_rs1 = 5'($urandom_range(0, 15));
            ID_rs2 = 5'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) begin
                rs = (p == 0) ? ID_rs1 : ID_rs2;
                if (rs == 5'd0)
                    push_exp($sformatf("rand_c%0d_p%0d", cyc, p), p[0], 32'h0, 1'b0, 4'd0);
                else if (ROB_commit_valid && ROB_commit_rd == rs && m_tag[rs] == ROB_commit_ROB_id)
                    push_exp($sformatf("rand_c%0d_p%0d_fwd", cyc, p), p[0], ROB_commit_value,
                             1'b0, ROB_commit_ROB_id);
                else
                    push_exp($sformatf("rand_c%0d_p%0d", cyc, p), p[0], m_val[rs], m_busy[rs],
                             m_tag[rs]);
            end
            #1;
            while (sbq.size() > 0) begin
                e = sbq.pop_front(); total++;
                got = e.port ? {RS_rs2_value, RS_rs2_busy, RS_rs2_ROB_id}
                             : {RS_rs1_value, RS_rs1_busy, RS_rs1_ROB_id};
                if (got !== {e.val, e.busy, e.tag}) begin
                    bad++;
                    $display("FAIL %s: got value=%h busy=%b tag=%0d want value=%h busy=%b tag=%0d",
                             e.name, got[36:5], got[4], got[3:0], e.val, e.busy, e.tag);
                end
            end
            // Advance the model to what the coming edge should leave behind.
            if (rdy) begin
                for (int r = 1; r < 32; r++) begin
                    if (ROB_commit_valid && ROB_commit_rd == 5'(r)) m_val[r] = ROB_commit_value;
                    if (ROB_roll_back_flag)
                        m_busy[r] = 1'b0;
                    else if (ID_rename_valid && ID_rename_rd == 5'(r)) begin
                        m_busy[r] = 1'b1;
                        m_tag[r]  = ID_rename_ROB_id;
                    end else if (ROB_commit_valid && ROB_commit_rd == 5'(r)
                                 && m_tag[r] == ROB_commit_ROB_id)
                        m_busy[r] = 1'b0;
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        rdy = 1'b1;
        clear_inputs();
        ID_rs1 = '0;
        ID_rs2 = '0;
        test_reset();
        test_rename_read();
        test_commit_forward();
        test_younger_rename();
        test_x0();
        test_rename_commit_same();
        test_roll_back();
        test_rdy_hold();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
